// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for a shared ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              gid_q;
    logic              grant;
    logic              idle;
    logic              accept;
    logic              op_supported;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic last_grant_q;
`endif

    // grant selects which requester would be accepted if it is valid
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // ready is masked during reset so every output shows its reset value
    assign idle       = (state_q == IDLE) && !reset;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign op_supported = (op_q <= OP_W'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gid_q       <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= grant ? req1_op : req0_op;
                        a_q     <= grant ? req1_a : req0_a;
                        b_q     <= grant ? req1_b : req0_b;
                        gid_q   <= grant;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= op_supported ? alu_result : '0;
                    resp_zero   <= alu_zero;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    // ALU inputs come straight from the capture registers, so they only move on accept
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    assign resp0_valid = (state_q == RESP) && !gid_q;
    assign resp1_valid = (state_q == RESP) && gid_q;
    assign busy        = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: an arbitration model predicts grants and a scoreboard
// checks each response's requester, value, zero flag and two-cycle latency.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    alu_arbiter #(
        .DATA_W(32),
        .OP_W  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp0_valid(resp0_valid),
        .resp1_valid(resp1_valid),
        .resp_result(resp_result),
        .resp_zero  (resp_zero),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    // Shared ALU; unsupported opcodes return junk the arbiter must suppress
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_a == alu_b);
    end

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        int          due;
    } sb_entry_t;

    sb_entry_t sb[$];
    logic      grant_log[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            default: return 32'h0;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: arbitration model plus scoreboard, sampled on the falling edge
    initial begin
        int        m_cnt;
        logic      m_last;
        logic      eg;
        logic      er0;
        logic      er1;
        sb_entry_t e;
        m_cnt  = 0;
        m_last = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cnt  = 0;
                m_last = 1'b1;
                sb.delete();
                check("rst_ready0", {31'b0, req0_ready}, 0);
                check("rst_ready1", {31'b0, req1_ready}, 0);
                check("rst_busy", {31'b0, busy}, 0);
                check("rst_resp_valid", {30'b0, resp1_valid, resp0_valid}, 0);
            end else begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    check("resp0_valid", {31'b0, resp0_valid}, {31'b0, !e.id});
                    check("resp1_valid", {31'b0, resp1_valid}, {31'b0, e.id});
                    check("resp_result", resp_result, e.res);
                    check("resp_zero", {31'b0, resp_zero}, {31'b0, e.zero});
                end else begin
                    check("no_resp", {30'b0, resp1_valid, resp0_valid}, 0);
                end

                check("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    eg = 1'b0;
`else
                    eg = ~m_last;
`endif
                end else begin
                    eg = req1_valid;
                end
                er0 = (m_cnt == 0) && req0_valid && !eg;
                er1 = (m_cnt == 0) && req1_valid && eg;
                check("ready0", {31'b0, req0_ready}, {31'b0, er0});
                check("ready1", {31'b0, req1_ready}, {31'b0, er1});

                if (er0 || er1) begin
                    e.id   = eg;
                    e.res  = eg ? exp_res(req1_op, req1_a, req1_b)
                                : exp_res(req0_op, req0_a, req0_b);
                    e.zero = eg ? (req1_a == req1_b) : (req0_a == req0_b);
                    e.due  = cyc + 2;
                    sb.push_back(e);
                    grant_log.push_back(req1_ready);
                    m_cnt  = 2;
                    m_last = eg;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic got;
        @(posedge clk);
        #1;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        check("accept_timeout", {31'b0, got}, 1);
        @(posedge clk);
        #1;
        // Scramble operands after accept; the arbiter must have latched them
        if (id) begin
            req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
        end else begin
            req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic expect_second;
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'hF0; req0_b = 32'h0F;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'h1;  req1_b = 32'h1;
        #12;
        check("rst_result", resp_result, 0);
        check("rst_zero", {31'b0, resp_zero}, 0);
        check("rst_alu_op", {29'b0, alu_op}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contention: both held valid from reset
        for (int i = 0; i < 40 && grant_log.size() < 3; i++) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("cont_timeout", {31'b0, grant_log.size() >= 3}, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        expect_second = 1'b0;
`else
        expect_second = 1'b1;
`endif
        if (grant_log.size() >= 3) begin
            check("cont_grant0", {31'b0, grant_log[0]}, 0);
            check("cont_grant1", {31'b0, grant_log[1]}, {31'b0, expect_second});
            check("cont_grant2", {31'b0, grant_log[2]}, 0);
        end
        repeat (4) @(posedge clk);
        #1;

        issue(1'b0, 3'b000, 32'd5, 32'd7);
        check("add_hold", resp_result, 32'd12);
        issue(1'b1, 3'b001, 32'h1234, 32'h1234);
        issue(1'b1, 3'b001, 32'd100, 32'd30);
        issue(1'b0, 3'b111, 32'd3, 32'd3);
        issue(1'b0, 3'b001, 32'd0, 32'd1);

        // Reset during EXEC
        @(posedge clk);
        #1;
        req0_op = 3'b000; req0_a = 32'd10; req0_b = 32'd20; req0_valid = 1'b1;
        for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_ready0", {31'b0, req0_ready}, 0);
        check("midrst_result", resp_result, 0);
        check("midrst_alu_a", alu_a, 0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b0, 3'b000, 32'd100, 32'd23);

        // Backpressure: req1 raised while req0's operation is in flight
        @(posedge clk);
        #1;
        req0_op = 3'b010; req0_a = 32'h0A00; req0_b = 32'h000B; req0_valid = 1'b1;
        for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_op = 3'b001; req1_a = 32'd50; req1_b = 32'd8; req1_valid = 1'b1;
        @(negedge clk);
        check("bp_exec_ready1", {31'b0, req1_ready}, 0);
        @(negedge clk);
        check("bp_resp_ready1", {31'b0, req1_ready}, 0);
        @(negedge clk);
        check("bp_idle_ready1", {31'b0, req1_ready}, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (ALUOp 3-bit; add/sub/or; result plus A==B zero flag). It accepts operations from two independent requesters through valid/ready handshakes and serializes them onto one ALU instance. It captures each operation, holds the ALU inputs stable for one execute cycle, registers the result, and returns it to the requester that issued it. It sits between the EX-stage issue logic and the ALU, so a single ALU can serve, for example, the EX stage and the branch-compare path.

## Interface
- DATA_W, 32, operand and result width.
- OP_W, 3, ALU opcode width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  arbiter accepts requester n this cycle.
- req0_op / req1_op  in  OP_W  opcode (000 add, 001 sub, 010 or).
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- resp0_valid / resp1_valid  out  1  one-cycle pulse; result for requester n is valid.
- resp_result  out  DATA_W  registered result, shared by both requesters.
- resp_zero  out  1  registered zero flag (1 when A==B).
- alu_op  out  OP_W  drives ALU ALUOp.
- alu_a / alu_b  out  DATA_W  drive ALU A and B.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero.
- busy  out  1  high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. State changes only on the rising edge of clk or on reset.
- IDLE:
  - reqN_ready is combinational: high only for the requester selected by arbitration, and only when that requester's reqN_valid is high. At most one ready is high in any cycle.
  - An accept is valid && ready at the clock edge. On accept, the arbiter latches op, a and b, records the granted ID, updates the priority pointer, and moves to EXEC.
- EXEC:
  - alu_op, alu_a and alu_b are driven from the latched registers.
  - At the clock edge, alu_result and alu_zero are captured into resp_result and resp_zero, and the FSM moves to RESP.
  - Unsupported opcodes (011–111) are still executed. resp_result is forced to 0 for these opcodes; resp_zero still comes from alu_zero.
- RESP: respN_valid is high for the granted ID only, for exactly one cycle. The FSM returns to IDLE.
- Outside EXEC, alu_* hold their last latched values, so the ALU inputs do not toggle.
- resp_result and resp_zero hold their values until the next EXEC capture.
- Arbitration, default (round-robin):
  - last_grant is a register. When both requesters are valid, the grant goes to the requester that is not last_grant.
  - When only one requester is valid, that requester is granted.
- Requesters must hold op, a and b stable while valid is high and ready is low. A requester may drop valid before it is accepted.

## Timing
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first tie), all ready=0, all resp*_valid=0, busy=0, resp_result=0, resp_zero=0, alu_op=0, alu_a=0, alu_b=0, latched operands=0.
- Latency: accept at edge N, then EXEC during cycle N+1, then respN_valid high during cycle N+2.
- Throughput: one operation every 3 cycles. ready is low in EXEC and RESP. The next accept can happen at the edge that ends the first IDLE cycle after RESP.
- Simultaneous valid in IDLE: exactly one requester is granted. The loser keeps valid asserted and is granted on the next IDLE cycle, which gives a worst-case wait of 3 cycles.
- Reset asserted mid-operation: all outputs go to their reset values immediately. The in-flight operation is discarded and no resp_valid is issued.
- A requester asserting valid during EXEC or RESP sees ready=0 and is not accepted.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Requester 0 always wins when both are valid, and last_grant is neither used nor updated.
  - Undefined: round-robin as described in Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single add: req0 op=000, a=5, b=7 -> req0_ready=1 at accept; resp0_valid=1 two cycles later with resp_result=12, resp_zero=0; resp1_valid stays 0.
- Sub, zero flag: req1 op=001, a=b=0x1234 -> resp1_valid with resp_result=0, resp_zero=1.
- Contention, round-robin: req0 and req1 both held valid from reset, req0 op=010 a=0xF0 b=0x0F, req1 op=000 a=1 b=1 -> req0 granted first (resp_result=0xFF), then req1 three cycles later (resp_result=2), then req0 again; with ALU_ARB_FIXED_PRIO_EN, req0 wins every arbitration.
- Unsupported opcode: req0 op=111, a=3, b=3 -> resp_result=0, resp_zero=1.
- Reset mid-op: assert reset during EXEC -> busy=0 and ready=0 immediately; no resp_valid after release; the next request completes normally with 2-cycle latency.
- Backpressure: req1 valid during EXEC -> req1_ready=0 until IDLE; req1 operands are held stable and then accepted correctly.
